// File: rtl/alu_sequencer.sv
// Issuing end of the CPU/ALU interface: accepts one decoded op per handshake,
// drives the ALU for ALU_LATENCY cycles, then captures result and flags.
module alu_sequencer #(
  parameter int ALU_LATENCY = 1,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  output logic              ready,
  input  logic [DATA_W-1:0] operation,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic              flag_we,
  input  logic              flush,
  output logic              done,
  output logic [DATA_W-1:0] res_l,
  output logic [DATA_W-1:0] res_h,
  output logic              carry_f,
  output logic              zero_f,
  output logic              sign_f,
  output logic              alu_rst,
  output logic              alu_enable,
  output logic [DATA_W-1:0] alu_operation,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic              alu_cpu_carry,
  input  logic [DATA_W-1:0] alu_result_l,
  input  logic [DATA_W-1:0] alu_result_h,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              alu_sign
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] opr_q, a_q, b_q;
  logic              we_q;
  logic [DATA_W-1:0] res_l_q, res_h_q;
  logic              c_q, z_q, s_q;
  logic              done_q, en_q, alu_rst_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      opr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      we_q      <= 1'b0;
      res_l_q   <= '0;
      res_h_q   <= '0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      s_q       <= 1'b0;
      done_q    <= 1'b0;
      en_q      <= 1'b0;
      alu_rst_q <= 1'b1;
    end else begin
      // A taken flush resets the ALU for exactly the following cycle.
      alu_rst_q <= flush;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req && !flush) begin
            opr_q   <= operation;
            a_q     <= op1;
            b_q     <= op2;
            we_q    <= flag_we;
            cnt_q   <= 4'(ALU_LATENCY - 1);
            en_q    <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (flush) begin
            en_q    <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q == 4'd0) begin
            res_l_q <= alu_result_l;
            res_h_q <= alu_result_h;
            if (we_q) begin
              c_q <= alu_carry;
              z_q <= alu_zero;
              s_q <= alu_sign;
            end
            en_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready         = (state_q == IDLE) && !rst;
  assign done          = done_q;
  assign res_l         = res_l_q;
  assign res_h         = res_h_q;
  assign carry_f       = c_q;
  assign zero_f        = z_q;
  assign sign_f        = s_q;
  assign alu_rst       = alu_rst_q;
  assign alu_enable    = en_q;
  assign alu_operation = opr_q;
  assign alu_op1       = a_q;
  assign alu_op2       = b_q;
  assign alu_cpu_carry = c_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: one instance with ALU_LATENCY=1 and one with 3,
// each checked against a transaction-level model of result and flag state.
module tb_alu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst, req, flag_we, flush;
  logic [1:0][7:0] operation, op1, op2;
  logic [1:0]      ready, done, carry_f, zero_f, sign_f;
  logic [1:0]      alu_rst, alu_enable, alu_cpu_carry;
  logic [1:0][7:0] res_l, res_h, alu_operation, alu_op1, alu_op2;
  logic [7:0]      stub_rl, stub_rh;
  logic            stub_c, stub_z, stub_s;

  alu_sequencer #(.ALU_LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst[0]), .req(req[0]), .ready(ready[0]),
    .operation(operation[0]), .op1(op1[0]), .op2(op2[0]),
    .flag_we(flag_we[0]), .flush(flush[0]), .done(done[0]),
    .res_l(res_l[0]), .res_h(res_h[0]), .carry_f(carry_f[0]),
    .zero_f(zero_f[0]), .sign_f(sign_f[0]), .alu_rst(alu_rst[0]),
    .alu_enable(alu_enable[0]), .alu_operation(alu_operation[0]),
    .alu_op1(alu_op1[0]), .alu_op2(alu_op2[0]),
    .alu_cpu_carry(alu_cpu_carry[0]), .alu_result_l(stub_rl),
    .alu_result_h(stub_rh), .alu_carry(stub_c), .alu_zero(stub_z),
    .alu_sign(stub_s));

  alu_sequencer #(.ALU_LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst[1]), .req(req[1]), .ready(ready[1]),
    .operation(operation[1]), .op1(op1[1]), .op2(op2[1]),
    .flag_we(flag_we[1]), .flush(flush[1]), .done(done[1]),
    .res_l(res_l[1]), .res_h(res_h[1]), .carry_f(carry_f[1]),
    .zero_f(zero_f[1]), .sign_f(sign_f[1]), .alu_rst(alu_rst[1]),
    .alu_enable(alu_enable[1]), .alu_operation(alu_operation[1]),
    .alu_op1(alu_op1[1]), .alu_op2(alu_op2[1]),
    .alu_cpu_carry(alu_cpu_carry[1]), .alu_result_l(stub_rl),
    .alu_result_h(stub_rh), .alu_carry(stub_c), .alu_zero(stub_z),
    .alu_sign(stub_s));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int lat [2] = '{1, 3};

  // Architectural state the sequencer should be holding, per instance.
  logic [7:0] m_rl [2];
  logic [7:0] m_rh [2];
  logic       m_c  [2];
  logic       m_z  [2];
  logic       m_s  [2];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_clear(input int k);
    m_rl[k] = 8'h00; m_rh[k] = 8'h00;
    m_c[k] = 1'b0; m_z[k] = 1'b0; m_s[k] = 1'b0;
  endtask

  // Issues one op on instance k from an IDLE cycle and follows it through
  // the EXEC window, the done pulse and the return to ready.
  task automatic run_op(input int k, input logic [7:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic we,
                        input logic [7:0] rl, input logic [7:0] rh,
                        input logic c, input logic z, input logic s,
                        output int done_cyc);
    logic [27:0] got, exp;
    stub_rl = rl; stub_rh = rh; stub_c = c; stub_z = z; stub_s = s;
    tests++;
    if (ready[k] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ready_before_req inst=%0d got=%b exp=1", k, ready[k]);
    end
    req[k] = 1'b1; operation[k] = op; op1[k] = a; op2[k] = b; flag_we[k] = we;
    tick();
    req[k] = 1'b0; operation[k] = $urandom; op1[k] = $urandom; op2[k] = $urandom;
    flag_we[k] = $urandom;
    for (int i = 0; i < lat[k]; i++) begin
      got = {alu_enable[k], done[k], ready[k], alu_operation[k], alu_op1[k],
             alu_op2[k], alu_cpu_carry[k]};
      exp = {1'b1, 1'b0, 1'b0, op, a, b, m_c[k]};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL exec_cycle%0d inst=%0d got=%h exp=%h", i, k, got, exp);
      end
      tick();
    end
    m_rl[k] = rl; m_rh[k] = rh;
    if (we) begin
      m_c[k] = c; m_z[k] = z; m_s[k] = s;
    end
    done_cyc = cyc;
    got = {7'd0, done[k], alu_enable[k], ready[k], res_l[k], res_h[k],
           carry_f[k], zero_f[k], sign_f[k]};
    exp = {7'd0, 1'b1, 1'b0, 1'b0, m_rl[k], m_rh[k], m_c[k], m_z[k], m_s[k]};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL done_capture inst=%0d got=%h exp=%h", k, got, exp);
    end
    tick();
    tests++;
    if ({done[k], ready[k], alu_cpu_carry[k]} !== {1'b0, 1'b1, m_c[k]}) begin
      fails++;
      $display("[TB] FAIL back_to_idle inst=%0d got=%b exp=%b", k,
               {done[k], ready[k], alu_cpu_carry[k]}, {1'b0, 1'b1, m_c[k]});
    end
  endtask

  task automatic test_reset();
    rst = 2'b11;
    #1;
    tests++;
    if ({ready, alu_rst} !== 4'b0011) begin
      fails++;
      $display("[TB] FAIL in_reset got=%b exp=0011", {ready, alu_rst});
    end
    tick(); tick();
    rst = 2'b00;
    model_clear(0); model_clear(1);
    tick();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if ({ready[k], done[k], alu_enable[k], alu_rst[k], res_l[k], res_h[k],
           carry_f[k], zero_f[k], sign_f[k]} !== {4'b1000, 16'h0000, 3'b000}) begin
        fails++;
        $display("[TB] FAIL reset_idle inst=%0d got=%b%b%b%b res=%h%h flags=%b%b%b",
                 k, ready[k], done[k], alu_enable[k], alu_rst[k], res_h[k], res_l[k],
                 carry_f[k], zero_f[k], sign_f[k]);
      end
    end
  endtask

  task automatic test_single_op();
    int dc;
    run_op(0, 8'h01, 8'hF0, 8'h20, 1'b1, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, dc);
    tests++;
    if ({res_l[0], carry_f[0], alu_cpu_carry[0]} !== {8'h10, 1'b1, 1'b1}) begin
      fails++;
      $display("[TB] FAIL single_op got=%h/%b/%b exp=10/1/1", res_l[0], carry_f[0],
               alu_cpu_carry[0]);
    end
  endtask

  task automatic test_flag_we_off();
    int dc;
    run_op(0, 8'h02, 8'h11, 8'h22, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, dc);
    tests++;
    if ({res_l[0], carry_f[0], zero_f[0], sign_f[0]} !== {8'h00, 3'b100}) begin
      fails++;
      $display("[TB] FAIL flag_we_off got=%h/%b%b%b exp=00/100", res_l[0],
               carry_f[0], zero_f[0], sign_f[0]);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    run_op(1, 8'h03, 8'hFF, 8'h01, 1'b1, 8'h00, 8'h01, 1'b1, 1'b1, 1'b0, d1);
    run_op(1, 8'h04, 8'h05, 8'h06, 1'b1, 8'h0C, 8'h00, 1'b0, 1'b0, 1'b0, d2);
    tests++;
    if (d2 - d1 !== 5) begin
      fails++;
      $display("[TB] FAIL done_spacing got=%0d exp=5", d2 - d1);
    end
  endtask

  task automatic test_flush();
    stub_rl = 8'hAA; stub_rh = 8'h55; stub_c = 1'b1; stub_z = 1'b1; stub_s = 1'b1;
    req[1] = 1'b1; operation[1] = 8'h07; op1[1] = 8'h01; op2[1] = 8'h02;
    flag_we[1] = 1'b1;
    tick();
    req[1] = 1'b0;
    tick();
    flush[1] = 1'b1;
    tick();
    flush[1] = 1'b0;
    tests++;
    if ({alu_enable[1], done[1], alu_rst[1], res_l[1], carry_f[1]} !==
        {3'b001, m_rl[1], m_c[1]}) begin
      fails++;
      $display("[TB] FAIL flush_edge got=%b%b%b res=%h c=%b exp=001 res=%h c=%b",
               alu_enable[1], done[1], alu_rst[1], res_l[1], carry_f[1], m_rl[1], m_c[1]);
    end
    tick();
    tests++;
    if ({ready[1], done[1], alu_rst[1], res_l[1]} !== {3'b100, m_rl[1]}) begin
      fails++;
      $display("[TB] FAIL flush_after got=%b%b%b res=%h exp=100 res=%h",
               ready[1], done[1], alu_rst[1], res_l[1], m_rl[1]);
    end
    req[1] = 1'b1; flush[1] = 1'b1;
    tick();
    req[1] = 1'b0; flush[1] = 1'b0;
    tests++;
    if ({alu_enable[1], ready[1]} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL flush_beats_req got=%b exp=01", {alu_enable[1], ready[1]});
    end
    tick();
  endtask

  task automatic test_random();
    int dc, k;
    logic [7:0] v [5];
    logic [2:0] f;
    for (int n = 0; n < 16; n++) begin
      k = n % 2;
      for (int j = 0; j < 5; j++) v[j] = 8'($urandom);
      f = 3'($urandom);
      run_op(k, v[0], v[1], v[2], 1'($urandom), v[3], v[4], f[0], f[1], f[2], dc);
    end
  endtask

  task automatic test_async_reset();
    int dc;
    run_op(0, 8'h09, 8'h80, 8'h80, 1'b1, 8'h00, 8'h01, 1'b1, 1'b1, 1'b0, dc);
    req[0] = 1'b1; operation[0] = 8'h0A; op1[0] = 8'h33; op2[0] = 8'h44;
    tick();
    req[0] = 1'b0;
    #2;
    rst[0] = 1'b1;
    #1;
    tests++;
    if ({ready[0], done[0], alu_enable[0], alu_rst[0], carry_f[0], alu_cpu_carry[0],
         res_h[0], alu_op1[0], alu_operation[0]} !== {6'b000100, 24'h000000}) begin
      fails++;
      $display("[TB] FAIL async_reset got=%b%b%b%b%b%b res_h=%h op1=%h opr=%h exp=000100",
               ready[0], done[0], alu_enable[0], alu_rst[0], carry_f[0],
               alu_cpu_carry[0], res_h[0], alu_op1[0], alu_operation[0]);
    end
    tick();
    rst[0] = 1'b0;
    model_clear(0);
    tick();
    tests++;
    if ({ready[0], alu_rst[0], carry_f[0]} !== 3'b100) begin
      fails++;
      $display("[TB] FAIL async_release got=%b exp=100", {ready[0], alu_rst[0], carry_f[0]});
    end
  endtask

  initial begin
    req = '0; flag_we = '0; flush = '0;
    operation = '0; op1 = '0; op2 = '0;
    stub_rl = '0; stub_rh = '0; stub_c = 1'b0; stub_z = 1'b0; stub_s = 1'b0;
    test_reset();
    test_single_op();
    test_flag_we_off();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
